// File: rtl/vga_pkg.sv
// Shared raster-mode constants, polarity type and helpers for the VGA timing path.
package vga_pkg;

    typedef enum logic {
        POL_NEG = 1'b0,
        POL_POS = 1'b1
    } pol_e;

    // Bundle of the three sync-side outputs that travel through the delay line together.
    typedef struct packed {
        logic h_sync;
        logic v_sync;
        logic vid_on;
    } sync_t;

    // XGA 1024x768@60
    localparam int XGA_H_ACTIVE = 1024;
    localparam int XGA_H_FP     = 24;
    localparam int XGA_H_SYNC   = 136;
    localparam int XGA_H_BP     = 160;
    localparam int XGA_V_ACTIVE = 768;
    localparam int XGA_V_FP     = 3;
    localparam int XGA_V_SYNC   = 6;
    localparam int XGA_V_BP     = 29;
    localparam pol_e XGA_H_POL  = POL_NEG;
    localparam pol_e XGA_V_POL  = POL_NEG;

    // VGA 640x480@60
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam pol_e VGA_H_POL  = POL_NEG;
    localparam pol_e VGA_V_POL  = POL_NEG;

    function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing bundle between the raster generator and the pixel renderer / RGB stage.
interface vga_timing_gen_if #(
    parameter int CW = 12
);
    logic          pix_ce;
    logic          h_sync;
    logic          v_sync;
    logic          vid_on;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          line_start;
    logic          frame_start;

    modport master (
        input  pix_ce,
        output h_sync, v_sync, vid_on, x, y, line_start, frame_start
    );

    modport slave (
        output pix_ce,
        input  h_sync, v_sync, vid_on, x, y, line_start, frame_start
    );
endinterface

// File: rtl/vga_delay_line.sv
// Clock-enable gated shift register with synchronous active-low clear to a fixed value.
module vga_delay_line #(
    parameter int               DEPTH   = 0,
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_bypass
        // Zero depth is a plain wire; the reduction only keeps the unused ports visible to lint.
        logic unused_bypass;
        assign unused_bypass = ^{clk, clear_n, ce};
        assign q = d;
    end else begin : g_shift
        logic [WIDTH-1:0] stage [DEPTH];

        always_ff @(posedge clk) begin
            if (!clear_n) begin
                for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
            end else if (ce) begin
                stage[0] <= d;
                for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end

        assign q = stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: h/v counters, registered sync/blank decode
// with an optional pixel-enable delay, and undelayed coordinates plus line/frame pulses.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   CW       = 12,
    parameter int   H_ACTIVE = XGA_H_ACTIVE,
    parameter int   H_FP     = XGA_H_FP,
    parameter int   H_SYNC   = XGA_H_SYNC,
    parameter int   H_BP     = XGA_H_BP,
    parameter int   V_ACTIVE = XGA_V_ACTIVE,
    parameter int   V_FP     = XGA_V_FP,
    parameter int   V_SYNC   = XGA_V_SYNC,
    parameter int   V_BP     = XGA_V_BP,
    parameter pol_e H_POL    = XGA_H_POL,
    parameter pol_e V_POL    = XGA_V_POL,
    parameter int   SYNC_DLY = 0
) (
    input  logic             clk_65M,
    input  logic             clear_n,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
        $error("vga_timing_gen: every porch and sync width must be at least 1");
    end
    if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_width
        $error("vga_timing_gen: raster totals do not fit in CW bits");
    end
    if (SYNC_DLY < 0 || SYNC_DLY > 7) begin : g_bad_dly
        $error("vga_timing_gen: SYNC_DLY must be in 0..7");
    end

    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END     = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END     = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          HS_ON      = logic'(H_POL);
    localparam logic          VS_ON      = logic'(V_POL);
    localparam sync_t         SYNC_IDLE  = '{h_sync: ~HS_ON, v_sync: ~VS_ON, vid_on: 1'b0};

    logic [CW-1:0] h;
    logic [CW-1:0] v;
    logic [CW-1:0] x_q;
    logic [CW-1:0] y_q;
    logic          line_q;
    logic          frame_q;
    sync_t         decode;
    sync_t         sync_q;
    sync_t         sync_dly;

    always_ff @(posedge clk_65M) begin
        if (!clear_n) begin
            h <= '0;
            v <= '0;
        end else if (vga.pix_ce) begin
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end
        end
    end

    always_comb begin
        decode        = SYNC_IDLE;
        decode.h_sync = (h >= HS_START && h < HS_END) ? HS_ON : ~HS_ON;
        decode.v_sync = (v >= VS_START && v < VS_END) ? VS_ON : ~VS_ON;
        decode.vid_on = (h < H_ACT_END) && (v < V_ACT_END);
    end

    // Outputs describe the pre-increment counter; pulses drop whenever the enable is low.
    always_ff @(posedge clk_65M) begin
        if (!clear_n) begin
            x_q     <= '0;
            y_q     <= '0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
            sync_q  <= SYNC_IDLE;
        end else begin
            line_q  <= vga.pix_ce && (h == '0);
            frame_q <= vga.pix_ce && (h == '0) && (v == '0);
            if (vga.pix_ce) begin
                x_q    <= h;
                y_q    <= v;
                sync_q <= decode;
            end
        end
    end

    vga_delay_line #(
        .DEPTH   (SYNC_DLY),
        .WIDTH   ($bits(sync_t)),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_dly (
        .clk     (clk_65M),
        .clear_n (clear_n),
        .ce      (vga.pix_ce),
        .d       (sync_q),
        .q       (sync_dly)
    );

    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.line_start  = line_q;
    assign vga.frame_start = frame_q;
    assign vga.h_sync      = sync_dly.h_sync;
    assign vga.v_sync      = sync_dly.v_sync;
    assign vga.vid_on      = sync_dly.vid_on;

endmodule
